// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared types and defaults for the banked memory window.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } clr_state_t;

    localparam logic [7:0]  c_fill_default          = 8'hEE;
    localparam logic [15:0] c_bank_reg_addr_default = 16'hFF70;

endpackage
`default_nettype wire

// File: rtl/mem_ram_sp.sv
`default_nettype none
// ============================================================================
//  Module      : mem_ram_sp
//  Description : Single-port synchronous RAM, read-first, no reset (block RAM).
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_ram_sp #(
    parameter int DEPTH = 32768,
    parameter int WIDTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_addr,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Read returns the old word when the same address is written.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        o_rdata <= r_mem[i_addr];
    end

endmodule
`default_nettype wire

// File: rtl/mem_banked.sv
`default_nettype none
// ============================================================================
//  Module      : mem_banked
//  Description : Two-half memory window (fixed bank 0 + switchable bank) with
//                a bank-select register and optional power-up fill sweep,
//                enabled by defining MEM_BANKED_CLEAR_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_banked
    import mem_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR     = 16'hC000,
    parameter int          BANK_SIZE     = 4096,
    parameter int          NUM_BANKS     = 8,
    parameter logic [15:0] BANK_REG_ADDR = c_bank_reg_addr_default,
    parameter logic [7:0]  FILL          = c_fill_default
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] addr_ext,
    inout  wire  [7:0]  data_ext,
    input  logic        mem_we,
    input  logic        mem_re,
    output logic        mem_ready,
    output logic        mem_busy
);

    localparam int c_off_w  = $clog2(BANK_SIZE);
    localparam int c_bank_w = $clog2(NUM_BANKS);
    localparam int c_depth  = BANK_SIZE * NUM_BANKS;
    localparam int c_idx_w  = $clog2(c_depth);

    logic                r_ready;
    logic                r_drive;
    logic                r_rd_reg;
    logic [7:0]          r_reg_rdata;
    logic [c_bank_w-1:0] r_bank_reg;

    logic                w_in_window;
    logic                w_upper;
    logic                w_reg_hit;
    logic                w_accept;
    logic                w_ext_we;
    logic [c_bank_w-1:0] w_eff_bank;
    logic [c_bank_w-1:0] w_bank;
    logic [c_idx_w-1:0]  w_idx;
    logic [7:0]          w_reg_view;
    logic                w_ram_we;
    logic [c_idx_w-1:0]  w_ram_addr;
    logic [7:0]          w_ram_wdata;
    logic [7:0]          w_ram_rdata;

    assign w_in_window = ({1'b0, addr_ext} >= {1'b0, BASE_ADDR}) &&
                         ({1'b0, addr_ext} <  {1'b0, BASE_ADDR} + 17'(2 * BANK_SIZE));
    assign w_upper     = ({1'b0, addr_ext} >= {1'b0, BASE_ADDR} + 17'(BANK_SIZE));
    assign w_reg_hit   = (addr_ext == BANK_REG_ADDR);

    // Bank 0 is already visible in the lower half, so selecting it aliases to 1.
    assign w_eff_bank  = (r_bank_reg == '0) ? c_bank_w'(1) : r_bank_reg;
    assign w_bank      = w_upper ? w_eff_bank : '0;
    assign w_idx       = {w_bank, addr_ext[c_off_w-1:0]};
    assign w_reg_view  = {{(8 - c_bank_w){1'b1}}, r_bank_reg};

    assign w_accept    = (mem_we || mem_re) && (w_in_window || w_reg_hit) && !mem_busy;
    assign w_ext_we    = mem_we && w_in_window && !w_reg_hit && !mem_busy;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ready     <= 1'b0;
            r_drive     <= 1'b0;
            r_rd_reg    <= 1'b0;
            r_reg_rdata <= '0;
            r_bank_reg  <= c_bank_w'(1);
        end else begin
            r_ready     <= w_accept;
            r_drive     <= w_accept && mem_re;
            r_rd_reg    <= w_reg_hit;
            r_reg_rdata <= w_reg_view;
            if (w_accept && mem_we && w_reg_hit) begin
                r_bank_reg <= data_ext[c_bank_w-1:0];
            end
        end
    end

`ifdef MEM_BANKED_CLEAR_EN
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(c_depth - 1);

    clr_state_t         r_state;
    clr_state_t         w_state_nxt;
    logic [c_idx_w-1:0] r_clr_idx;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= CLEAR;
            r_clr_idx <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == CLEAR) begin
                r_clr_idx <= r_clr_idx + 1'b1;
            end
        end
    end

    // The sweep owns the RAM port while it runs.
    always_comb begin
        w_state_nxt = r_state;
        w_ram_we    = w_ext_we;
        w_ram_addr  = w_idx;
        w_ram_wdata = data_ext;
        case (r_state)
            CLEAR: begin
                w_ram_we    = 1'b1;
                w_ram_addr  = r_clr_idx;
                w_ram_wdata = FILL;
                if (r_clr_idx == c_last_idx) begin
                    w_state_nxt = READY;
                end
            end
            default: w_state_nxt = READY;
        endcase
    end

    assign mem_busy = (r_state == CLEAR);
`else
    assign w_ram_we    = w_ext_we;
    assign w_ram_addr  = w_idx;
    assign w_ram_wdata = data_ext;
    assign mem_busy    = 1'b0;
`endif

    mem_ram_sp #(
        .DEPTH (c_depth),
        .WIDTH (8)
    ) u_ram (
        .i_clk   (clock),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

    assign mem_ready = r_ready;
    assign data_ext  = r_drive ? (r_rd_reg ? r_reg_rdata : w_ram_rdata) : 8'bz;

endmodule
`default_nettype wire

// File: tb/tb_mem_banked.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_banked
//  Description : Self-checking bench for mem_banked against a byte-array model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_banked;

    logic        clock;
    logic        reset;
    logic [15:0] addr_ext;
    wire  [7:0]  data_ext;
    logic        mem_we;
    logic        mem_re;
    logic        mem_ready;
    logic        mem_busy;

    logic        tb_oe;
    logic [7:0]  tb_drv;

    int          n_cmp;
    int          n_bad;
    bit          sweep_on;
    int          br;
    logic [7:0]  mdl [int];

    assign data_ext = tb_oe ? tb_drv : 8'bz;

    mem_banked dut (
        .clock     (clock),
        .reset     (reset),
        .addr_ext  (addr_ext),
        .data_ext  (data_ext),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_ready (mem_ready),
        .mem_busy  (mem_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit in_win(input logic [15:0] a);
        return (int'(a) >= 'hC000) && (int'(a) < 'hE000);
    endfunction

    function automatic int phys(input logic [15:0] a);
        int off;
        int b;
        off = int'(a) - 'hC000;
        if (off < 4096) return off;
        b = (br == 0) ? 1 : br;
        return b * 4096 + (off - 4096);
    endfunction

    // One access with an idle cycle before it; result checked in the cycle after sampling.
    task automatic access(input bit we, input bit re, input logic [15:0] a,
                          input logic [7:0] d, input bit busy, input string tag);
        bit         acc;
        bit         known;
        logic [7:0] exp_d;
        acc   = (in_win(a) || a == 16'hFF70) && !busy && (we || re);
        known = 1'b0;
        exp_d = 8'h00;
        if (acc && re) begin
            if (a == 16'hFF70) begin
                exp_d = 8'hF8 | 8'(br);
                known = 1'b1;
            end else if (mdl.exists(phys(a))) begin
                exp_d = mdl[phys(a)];
                known = 1'b1;
            end else if (sweep_on) begin
                exp_d = 8'hEE;
                known = 1'b1;
            end
        end
        @(posedge clock); #1;
        addr_ext = a; mem_we = we; mem_re = re; tb_drv = d; tb_oe = we;
        @(posedge clock); #1;
        mem_we = 1'b0; mem_re = 1'b0;
        tb_oe  = !(acc && re); tb_drv = 8'h00;
        #1;
        check({tag, "_ready"}, 32'(mem_ready), 32'(acc));
        if (acc && re) begin
            if (known) check({tag, "_data"}, 32'(data_ext), 32'(exp_d));
        end else begin
            check({tag, "_nodrive"}, 32'(data_ext), 32'h0);
        end
        tb_oe = 1'b0;
        if (acc && we) begin
            if (a == 16'hFF70) br = int'(d) % 8;
            else mdl[phys(a)] = d;
        end
    endtask

    task automatic wait_sweep(output int cnt);
        cnt = 0;
        while (mem_busy && cnt < 40000) begin
            @(posedge clock); #1;
            cnt++;
        end
    endtask

    logic [15:0] burst_a [4] = '{16'hC123, 16'hD010, 16'hFF70, 16'hD010};
    logic [7:0]  burst_d [4] = '{8'h33, 8'h5A, 8'hFB, 8'h5A};

    initial begin
        int         cnt;
        int         k;
        logic [15:0] ra;
        logic [7:0]  rd;
        n_cmp = 0; n_bad = 0; br = 1;
        reset = 1'b1; addr_ext = 16'h0; mem_we = 1'b0; mem_re = 1'b0;
        tb_oe = 1'b1; tb_drv = 8'h00;

        repeat (3) @(posedge clock);
        #1;
        check("rst_ready", 32'(mem_ready), 32'h0);
        check("rst_nodrive", 32'(data_ext), 32'h0);
        sweep_on = mem_busy;
        tb_oe = 1'b0;
        #2 reset = 1'b0;
        wait_sweep(cnt);
        if (sweep_on) check("sweep_len", 32'(cnt), 32'd32768);
        check("idle_after_sweep", 32'(mem_busy), 32'h0);

        access(0, 1, 16'hFF70, 8'h00, 0, "rst_bank");
        access(0, 1, 16'hC000, 8'h00, 0, "clr_c000");
        access(0, 1, 16'hD000, 8'h00, 0, "clr_d000");
        access(0, 1, 16'hDFFF, 8'h00, 0, "clr_dfff");

        // Banking
        access(1, 0, 16'hFF70, 8'h05, 0, "bk_sel5a");
        access(1, 0, 16'hD010, 8'hEE, 0, "bk_pre5");
        access(1, 0, 16'hFF70, 8'h03, 0, "bk_sel3");
        access(1, 0, 16'hD010, 8'h5A, 0, "bk_wr3");
        access(1, 0, 16'hFF70, 8'h05, 0, "bk_sel5");
        access(0, 1, 16'hD010, 8'h00, 0, "bk_rd5");
        access(1, 0, 16'hFF70, 8'h03, 0, "bk_sel3b");
        access(0, 1, 16'hD010, 8'h00, 0, "bk_rd3");

        // Bank zero aliases to bank one
        access(1, 0, 16'hFF70, 8'h00, 0, "b0_sel0");
        access(1, 0, 16'hD000, 8'h11, 0, "b0_wr");
        access(1, 0, 16'hFF70, 8'h01, 0, "b0_sel1");
        access(0, 1, 16'hD000, 8'h00, 0, "b0_rd");
        access(0, 1, 16'hFF70, 8'h00, 0, "b0_reg");

        // Read-first on simultaneous write/read
        access(1, 0, 16'hC123, 8'h22, 0, "rf_init");
        access(1, 1, 16'hC123, 8'h33, 0, "rf_both");
        access(0, 1, 16'hC123, 8'h00, 0, "rf_after");

        // Misses and upper bits of bank register
        access(0, 1, 16'h8000, 8'h00, 0, "miss_rd");
        access(1, 0, 16'hE010, 8'h77, 0, "miss_wr");
        access(1, 0, 16'hFF70, 8'hFE, 0, "reg_hibits");
        access(0, 1, 16'hFF70, 8'h00, 0, "reg_rd6");
        access(1, 0, 16'hFF70, 8'h03, 0, "reg_back3");

        // Back-to-back reads
        @(posedge clock); #1;
        for (int j = 0; j < 4; j++) begin
            addr_ext = burst_a[j]; mem_re = 1'b1;
            @(posedge clock); #1;
            check($sformatf("burst%0d_ready", j), 32'(mem_ready), 32'h1);
            check($sformatf("burst%0d_data", j), 32'(data_ext), 32'(burst_d[j]));
        end
        mem_re = 1'b0;

        // Random traffic against the model
        for (int i = 0; i < 300; i++) begin
            k  = $urandom_range(0, 9);
            rd = 8'($urandom);
            ra = 16'hC000 + 16'($urandom_range(0, 1)) * 16'h1000 + 16'($urandom_range(0, 7));
            case (k)
                0, 1, 2: access(1, 0, ra, rd, 0, "rnd_wr");
                3, 4, 5: access(0, 1, ra, rd, 0, "rnd_rd");
                6:       access(1, 0, 16'hFF70, rd, 0, "rnd_bkwr");
                7:       access(0, 1, 16'hFF70, rd, 0, "rnd_bkrd");
                8:       access(1, 1, ra, rd, 0, "rnd_both");
                default: access(rd[0], !rd[0], 16'hE000 + 16'($urandom_range(0, 16'h0FFF)), rd, 0, "rnd_miss");
            endcase
        end

        // Reset while a read is pending
        @(posedge clock); #1;
        addr_ext = 16'hC000; mem_re = 1'b1;
        @(posedge clock); #1;
        mem_re = 1'b0; reset = 1'b1; tb_oe = 1'b1; tb_drv = 8'h00;
        #1;
        check("rstrd_ready", 32'(mem_ready), 32'h0);
        check("rstrd_nodrive", 32'(data_ext), 32'h0);
        check("rstrd_busy", 32'(mem_busy), 32'(sweep_on));
        tb_oe = 1'b0;
        br = 1;
        mdl.delete();
        @(negedge clock);
        reset = 1'b0;

        if (sweep_on) begin
            repeat (100) @(posedge clock);
            access(0, 1, 16'hC000, 8'h00, 1, "busy_rd");
            access(1, 0, 16'hFF70, 8'h06, 1, "busy_wr");
            check("midsweep_busy", 32'(mem_busy), 32'h1);
            reset = 1'b1;
            #2 reset = 1'b0;
            wait_sweep(cnt);
            check("restart_len", 32'(cnt), 32'd32768);
            access(0, 1, 16'hC000, 8'h00, 0, "final_c000");
        end
        access(0, 1, 16'hFF70, 8'h00, 0, "final_bank");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_banked.md
MEM_BANKED -- requirements
Module: mem_banked

Interface
REQ-001 Parameter BASE_ADDR, default 16'hC000, is the first byte address of the memory window.
REQ-002 Parameter BANK_SIZE, default 4096, gives the bytes per bank and SHALL be a power of two.
REQ-003 Parameter NUM_BANKS, default 8, gives the total bank count and SHALL be a power of two, >= 2.
REQ-004 Parameter BANK_REG_ADDR, default 16'hFF70, is the address of the bank-select register.
REQ-005 Parameter FILL, default 8'hEE, is the value written to every byte by the clear sweep.
REQ-006 clock  input  1  sole clock; all state updates on posedge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 addr_ext  input  16  byte address.
REQ-009 data_ext  inout  8  shared data bus; block drives it only while returning read data, else 8'bz.
REQ-010 mem_we  input  1  write request, sampled at posedge.
REQ-011 mem_re  input  1  read request, sampled at posedge.
REQ-012 mem_ready  output  1  one-cycle pulse acknowledging an accepted access.
REQ-013 mem_busy  output  1  high while the clear sweep runs; accesses are ignored.

Function
REQ-014 Hit SHALL be addr in [BASE_ADDR, BASE_ADDR+2*BANK_SIZE), or addr == BANK_REG_ADDR; non-hit accesses are ignored, with no mem_ready and no bus drive.
REQ-015 The lower half of the window SHALL map to bank 0; the upper half SHALL map to bank eff_bank.
REQ-016 eff_bank SHALL be bank_reg, except that a value of 0 maps to 1.
REQ-017 Physical index SHALL be {bank, addr[log2(BANK_SIZE)-1:0]}, for a total depth of BANK_SIZE*NUM_BANKS.
REQ-018 Write: with mem_we and hit and !mem_busy at edge N, the byte SHALL be stored at edge N, and mem_ready SHALL be high during cycle N+1.
REQ-019 Write to BANK_REG_ADDR SHALL load bank_reg with data_ext[log2(NUM_BANKS)-1:0]; higher bits SHALL be discarded.
REQ-020 Read: with mem_re and hit and !mem_busy at edge N, data_ext SHALL carry the byte and mem_ready SHALL be high for exactly cycle N+1 (1-cycle latency).
REQ-021 A read of BANK_REG_ADDR SHALL return the upper bits as 1s and the low bits as bank_reg.
REQ-022 Back-to-back reads SHALL give one result per cycle, with no bubble.
REQ-023 When mem_we and mem_re are both set to the same address, the block SHALL perform both, return the pre-write data (read-first), and issue one mem_ready pulse.
REQ-024 A bank_reg write SHALL affect only accesses sampled at later edges.
REQ-025 Clear FSM states SHALL be CLEAR and READY.
REQ-026 In CLEAR, the FSM SHALL write FILL to the counter index each cycle, increment the counter, and move to READY after index SIZE-1.
REQ-027 In CLEAR, mem_busy SHALL be 1 and external accesses SHALL be dropped.

Reset
REQ-028 On reset assertion, asynchronously: mem_ready=0, data_ext=Z, bank_reg=1, clear counter=0, FSM=CLEAR (macro on) or READY (macro off).
REQ-029 Reset during CLEAR SHALL restart the sweep from index 0.
REQ-030 Reset during a pending read SHALL cancel it, with no mem_ready and no bus drive.

Configuration
REQ-031 With MEM_BANKED_CLEAR_EN defined, the CLEAR sweep SHALL run after every reset, taking BANK_SIZE*NUM_BANKS cycles, and mem_busy SHALL follow the FSM.
REQ-032 With MEM_BANKED_CLEAR_EN undefined, no sweep logic SHALL exist, mem_busy SHALL be tied 0, accesses SHALL be accepted from the first edge after reset release, and contents SHALL be unspecified.

Structure
REQ-033 Package mem_pkg SHALL hold the FSM state enum, the FILL default, and the BANK_REG_ADDR default.
REQ-034 Storage SHALL be the sub-module mem_ram_sp: a single-port synchronous RAM with parameter depth, read-first, and no reset, so that it infers block RAM.

Verification
REQ-035 Clear: release reset, wait for mem_busy to fall (32768 cycles), read C000, D000 and DFFF -> each returns 8'hEE.
REQ-036 Banking: write FF70=3, write D010=8'h5A, write FF70=5, read D010 -> 8'hEE; write FF70=3, read D010 -> 8'h5A.
REQ-037 Bank zero: write FF70=0, write D000=8'h11, write FF70=1, read D000 -> 8'h11; read FF70 -> 8'hF9.
REQ-038 Read-first: with C123=8'h22, assert we+re at C123 with data 8'h33 -> data_ext=8'h22 at N+1; next read -> 8'h33.
REQ-039 Miss and busy: read 8000 -> no mem_ready, data_ext=Z; access C000 while mem_busy=1 -> ignored; reset mid-sweep -> sweep restarts at index 0.
